// File: rtl/mem_bus_arbiter.sv
// Central round-robin owner arbiter for the shared memory bus: one-hot registered grant,
// grant timeout, one-cycle bus turnaround. Define MEM_BUS_ARB_WATCHDOG_EN for the ownership watchdog.
module mem_bus_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int IDXW          = 2,
  parameter int GRANT_TIMEOUT = 4,
  parameter int MAX_HOLD      = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] busy_in,
  output logic [NUM_REQ-1:0] grant,
  output logic               bus_busy,
  output logic [IDXW-1:0]    owner,
  output logic               owner_valid,
  output logic               proto_err,
  output logic               hold_err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_OWNED = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;
  localparam logic [3:0] TMO_LAST = 4'(GRANT_TIMEOUT - 1);

  logic [1:0]         state;
  logic [IDXW-1:0]    rr, rr_next, pick, sel;
  logic               pick_vld, own_busy, wd_fire;
  logic [3:0]         tmo_cnt;
  logic [NUM_REQ-1:0] foreign;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2**IDXW) < NUM_REQ || GRANT_TIMEOUT < 1 ||
      GRANT_TIMEOUT > 15 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("mem_bus_arbiter: parameter out of range");
  end

  assign bus_busy = |busy_in;
  assign own_busy = busy_in[owner];
  assign rr_next  = (owner == IDXW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Any busy driver that is not the live grantee is a protocol violation.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign foreign[i] = busy_in[i] & ~(owner_valid & (owner == IDXW'(i)));
  end

  // Walk downward so the requester closest to rr (upward, with wrap) is the last writer.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    sel      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel = IDXW'((int'(rr) + k) % NUM_REQ);
      if (req[sel]) begin
        pick     = sel;
        pick_vld = 1'b1;
      end
    end
  end

`ifdef MEM_BUS_ARB_WATCHDOG_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  assign wd_fire = (state == S_OWNED) && own_busy && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      hold_err <= 1'b0;
    end else if (state == S_GRANT) begin
      hold_cnt <= '0;
    end else if (state == S_OWNED) begin
      hold_cnt <= hold_cnt + 8'd1;
      if (wd_fire) hold_err <= 1'b1;
    end
  end
`else
  assign wd_fire  = 1'b0;
  assign hold_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      grant       <= '0;
      owner       <= '0;
      owner_valid <= 1'b0;
      rr          <= '0;
      tmo_cnt     <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (|foreign) proto_err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant       <= NUM_REQ'(1) << pick;
            owner       <= pick;
            owner_valid <= 1'b1;
            tmo_cnt     <= '0;
            state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (own_busy) begin
            state <= S_OWNED;
          end else if (!req[owner]) begin
            grant       <= '0;
            owner_valid <= 1'b0;
            state       <= S_TURN;
          end else if (tmo_cnt == TMO_LAST) begin
            grant       <= '0;
            owner_valid <= 1'b0;
            proto_err   <= 1'b1;
            rr          <= rr_next;
            state       <= S_TURN;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        S_OWNED: begin
          if (!own_busy || wd_fire) begin
            grant       <= '0;
            owner_valid <= 1'b0;
            rr          <= rr_next;
            state       <= S_TURN;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized traffic
// against a cycle-level behavioural model of the ownership rules.
module tb_mem_bus_arbiter;
  localparam int N = 3, IW = 2, TMO = 4, MH = 8;

  logic          clk = 1'b0, reset = 1'b1;
  logic [N-1:0]  req = '0, busy_in = '0;
  logic [N-1:0]  grant;
  logic          bus_busy, owner_valid, proto_err, hold_err;
  logic [IW-1:0] owner;
  int            n_tests = 0, n_fail = 0;

  // model: who owns the bus, whether they have claimed it, and how long for
  bit m_ov, m_owned, m_perr, m_herr;
  int m_owner, m_age, m_hold, m_gap, m_rr;

  mem_bus_arbiter #(.NUM_REQ(N), .IDXW(IW), .GRANT_TIMEOUT(TMO), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset), .req(req), .busy_in(busy_in), .grant(grant),
    .bus_busy(bus_busy), .owner(owner), .owner_valid(owner_valid),
    .proto_err(proto_err), .hold_err(hold_err));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [N-1:0] m_grant();
    return m_ov ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic m_release();
    m_ov = 0; m_owned = 0; m_gap = 1; m_rr = (m_owner + 1) % N;
  endtask

  task automatic model_step();
    if (reset) begin
      m_ov = 0; m_owned = 0; m_owner = 0; m_age = 0; m_hold = 0;
      m_gap = 0; m_rr = 0; m_perr = 0; m_herr = 0;
      return;
    end
    for (int j = 0; j < N; j++)
      if (busy_in[j] && !(m_ov && m_owner == j)) m_perr = 1;
    if (m_ov && !m_owned) begin
      if (busy_in[m_owner]) begin
        m_owned = 1; m_hold = 0;
      end else if (!req[m_owner]) begin
        m_ov = 0; m_gap = 1;
      end else begin
        m_age++;
        if (m_age == TMO) begin m_perr = 1; m_release(); end
      end
    end else if (m_ov) begin
      if (!busy_in[m_owner]) m_release();
      else begin
`ifdef MEM_BUS_ARB_WATCHDOG_EN
        m_hold++;
        if (m_hold == MH) begin m_herr = 1; m_release(); end
`endif
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (req != 0) begin
      for (int k = 0; k < N; k++)
        if (req[(m_rr + k) % N]) begin m_owner = (m_rr + k) % N; break; end
      m_ov = 1; m_owned = 0; m_age = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; req = '0; busy_in = '0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req = 3'b011; busy_in = 3'b101;
    tick(); tick();
    n_tests++;
    if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL reset_bus_busy: got %b want 1", bus_busy); end
    n_tests++;
    if (grant !== '0 || owner_valid !== 1'b0 || owner !== '0 || proto_err !== 1'b0 || hold_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: grant=%b ov=%b owner=%0d perr=%b herr=%b want all 0",
               grant, owner_valid, owner, proto_err, hold_err);
    end
    reset = 0; req = '0; busy_in = '0;
    tick();
    n_tests++;
    if (bus_busy !== 1'b0 || grant !== '0) begin
      n_fail++; $display("FAIL reset_idle: bus_busy=%b grant=%b want 0 000", bus_busy, grant);
    end
  endtask

  task automatic test_single();
    bit ok = 1;
    do_reset();
    req = 3'b010;
    tick();
    n_tests++;
    if (grant !== 3'b010 || owner !== 2'd1 || owner_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: grant=%b owner=%0d ov=%b want 010 1 1", grant, owner, owner_valid);
    end
    tick(); tick();
    busy_in = 3'b010;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (grant !== 3'b010) ok = 0;
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL single_hold: grant=%b want 010 through busy", grant); end
    busy_in = '0; req = 3'b111;
    tick();
    n_tests++;
    if (grant !== '0 || owner_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_release: grant=%b ov=%b want 000 0", grant, owner_valid);
    end
    tick();
    n_tests++;
    if (grant !== '0) begin n_fail++; $display("FAIL single_turn: grant=%b want 000", grant); end
    tick();
    n_tests++;
    if (grant !== 3'b100 || grant !== m_grant()) begin
      n_fail++; $display("FAIL single_rr: grant=%b want 100 (model %b)", grant, m_grant());
    end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_round_robin();
    int order[4] = '{0, 1, 2, 0};
    int gap = 0, seen = 0, bleft = 0;
    logic [N-1:0] prev = '0;
    do_reset();
    req = 3'b111;
    for (int c = 0; c < 80 && seen < 4; c++) begin
      if (grant != 0 && prev == 0) begin
        n_tests++;
        if (owner !== IW'(order[seen])) begin
          n_fail++; $display("FAIL rr_order[%0d]: owner=%0d want %0d", seen, owner, order[seen]);
        end
        if (seen > 0) begin
          n_tests++;
          if (gap != 2) begin n_fail++; $display("FAIL rr_gap[%0d]: no-grant cycles=%0d want 2", seen, gap); end
        end
        seen++; busy_in = grant; bleft = 3;
      end
      n_tests++;
      if ($countones(grant) > 1 || grant !== m_grant()) begin
        n_fail++; $display("FAIL rr_onehot: grant=%b want %b", grant, m_grant());
      end
      gap = (grant == 0) ? gap + 1 : 0;
      prev = grant;
      tick();
      if (bleft > 0) begin
        bleft--;
        if (bleft == 0) busy_in = '0;
      end
    end
    n_tests++;
    if (seen != 4) begin n_fail++; $display("FAIL rr_count: grants=%0d want 4", seen); end
    req = '0; busy_in = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    do_reset();
    req = 3'b001;
    tick();
    n_tests++;
    if (grant !== 3'b001 || proto_err !== 1'b0) begin
      n_fail++; $display("FAIL tmo_grant: grant=%b perr=%b want 001 0", grant, proto_err);
    end
    req = 3'b011;
    for (int c = 0; c < 20 && grant != 0; c++) begin cnt++; tick(); end
    n_tests++;
    if (cnt != TMO) begin n_fail++; $display("FAIL tmo_len: grant cycles=%0d want %0d", cnt, TMO); end
    n_tests++;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL tmo_perr: got %b want 1", proto_err); end
    for (int c = 0; c < 10 && grant == 0; c++) tick();
    n_tests++;
    if (grant !== 3'b010) begin n_fail++; $display("FAIL tmo_next: grant=%b want 010", grant); end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_foreign_busy();
    do_reset();
    req = 3'b001;
    tick();
    busy_in = 3'b001;
    tick();
    n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL foreign_pre: perr=%b want 0", proto_err); end
    busy_in = 3'b101;
    tick();
    n_tests++;
    if (proto_err !== 1'b1 || owner !== 2'd0 || grant !== 3'b001 || owner_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL foreign_busy: perr=%b owner=%0d grant=%b ov=%b want 1 0 001 1", proto_err, owner, grant, owner_valid);
    end
    busy_in = 3'b001;
    tick();
    n_tests++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL foreign_keep: grant=%b want 001", grant); end
    busy_in = '0; req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 3'b010;
    tick();
    busy_in = 3'b010; tick();
    busy_in = 3'b110; tick();
    busy_in = 3'b010; tick();
    n_tests++;
    if (proto_err !== 1'b1 || grant !== 3'b010) begin
      n_fail++; $display("FAIL mid_pre: perr=%b grant=%b want 1 010", proto_err, grant);
    end
    reset = 1;
    tick();
    n_tests++;
    if (grant !== '0 || owner_valid !== 1'b0 || owner !== '0 || proto_err !== 1'b0 || hold_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b ov=%b owner=%0d perr=%b herr=%b want all 0",
               grant, owner_valid, owner, proto_err, hold_err);
    end
    n_tests++;
    if (bus_busy !== 1'b1) begin n_fail++; $display("FAIL mid_bus_busy: got %b want 1", bus_busy); end
    reset = 0; busy_in = '0; req = 3'b011;
    tick();
    n_tests++;
    if (grant !== 3'b001) begin n_fail++; $display("FAIL mid_idle: grant=%b want 001", grant); end
    req = '0;
    tick(); tick(); tick();
  endtask

  task automatic test_watchdog();
    int cnt = 0, exp_cnt;
    logic exp_herr;
    logic [N-1:0] prev = '0, nxt = '0, exp_nxt;
`ifdef MEM_BUS_ARB_WATCHDOG_EN
    exp_cnt = MH + 1; exp_herr = 1'b1; exp_nxt = 3'b010;
`else
    exp_cnt = 20;     exp_herr = 1'b0; exp_nxt = 3'b000;
`endif
    do_reset();
    req = 3'b011;
    tick();
    busy_in = 3'b001;
    for (int c = 0; c < 20; c++) begin
      if (grant == 3'b001) cnt++;
      if (prev == 0 && grant != 0 && nxt == 0 && c > 0) nxt = grant;
      prev = grant;
      tick();
    end
    n_tests++;
    if (cnt != exp_cnt) begin n_fail++; $display("FAIL wd_len: grant cycles=%0d want %0d", cnt, exp_cnt); end
    n_tests++;
    if (hold_err !== exp_herr) begin n_fail++; $display("FAIL wd_herr: got %b want %b", hold_err, exp_herr); end
    n_tests++;
    if (nxt !== exp_nxt) begin n_fail++; $display("FAIL wd_next: grant=%b want %b", nxt, exp_nxt); end
    busy_in = '0; req = '0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_random();
    logic [N-1:0] prev = '0;
    int b_who = 0, b_wait = 0, b_len = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      if (reset) b_len = 0;
      else if (grant != 0 && prev == 0) begin
        b_who = int'(owner); b_wait = $urandom_range(0, 5); b_len = $urandom_range(1, 12);
      end
      busy_in = '0;
      if (b_len > 0) begin
        if (b_wait > 0) b_wait--;
        else begin busy_in[b_who] = 1'b1; b_len--; end
      end
      if ($urandom_range(0, 99) == 0) busy_in[$urandom_range(0, N - 1)] = 1'b1;
      prev = grant;
      tick();
      n_tests++;
      if (grant !== m_grant() || owner_valid !== m_ov || (m_ov && owner !== IW'(m_owner)) ||
          proto_err !== m_perr || hold_err !== m_herr || bus_busy !== (|busy_in)) begin
        n_fail++;
        if (n_fail < 10)
          $display("FAIL random[%0d]: grant=%b ov=%b owner=%0d perr=%b herr=%b want grant=%b ov=%b owner=%0d perr=%b herr=%b",
                   c, grant, owner_valid, owner, proto_err, hold_err, m_grant(), m_ov, m_owner, m_perr, m_herr);
      end
    end
    reset = 0; req = '0; busy_in = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_foreign_busy();
    test_reset_mid();
    test_watchdog();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
